// File: rtl/ascii2bin_pkg.sv
// -----------------------------------------------------------------------------
// ascii2bin_pkg
// Shared definitions for the ASCII-decimal to binary conversion path.
//   - state_t     : controller states (IDLE, COLLECT, CONVERT, HOLD)
//   - ASCII_*     : character constants used by the parser
//   - is_digit()  : true for the characters '0'..'9'
// Optional feature macro used by importers: ASCII2BIN_BACKSPACE_EN
// -----------------------------------------------------------------------------
package ascii2bin_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CONVERT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_BS   = 8'h08;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage : ascii2bin_pkg

// File: rtl/module_bcd2binary.sv
// -----------------------------------------------------------------------------
// module_bcd2binary
// Combinational MAX_DIGITS-digit packed BCD to unsigned binary converter.
// Digit 0 (least significant) lives in bcd_in[3:0]. Evaluated Horner-style,
// most significant digit first, with x10 built as (x<<3)+(x<<1) so no
// multiplier or divider is inferred.
// Ports:
//   bcd_in   in   4*MAX_DIGITS  packed BCD digits
//   bin_out  out  WIDTH         low WIDTH bits of the converted value
//   overflow out  1             converted value exceeds 2^WIDTH-1
// Optional feature macro: none (ASCII2BIN_BACKSPACE_EN lives in the top).
// -----------------------------------------------------------------------------
module module_bcd2binary #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic [4*MAX_DIGITS-1:0] bcd_in,
    output logic [WIDTH-1:0]        bin_out,
    output logic                    overflow
);

    // 10^n < 16^n, so 4*MAX_DIGITS bits always hold the full sum without
    // wrapping; WIDTH+4 keeps at least one bit above the result for overflow.
    localparam int SUM_W = ((WIDTH + 4) > (4 * MAX_DIGITS)) ? (WIDTH + 4)
                                                             : (4 * MAX_DIGITS);

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            sum = (sum << 3) + (sum << 1) + SUM_W'(bcd_in[4*i +: 4]);
        end
    end

    assign bin_out  = sum[WIDTH-1:0];
    assign overflow = |sum[SUM_W-1:WIDTH];

endmodule : module_bcd2binary

// File: rtl/module_ascii2binary.sv
// -----------------------------------------------------------------------------
// module_ascii2binary
// Accepts a serial stream of ASCII decimal characters, collects up to
// MAX_DIGITS digits as BCD and, on TERM_CHAR, converts them to an unsigned
// WIDTH-bit value presented on a valid/ready handshake.
// Ports:
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset
//   ascii_in      in   8      incoming character
//   ascii_valid   in   1      ascii_in valid this cycle
//   ascii_ready   out  1      character accepted this cycle (IDLE/COLLECT)
//   result        out  WIDTH  converted value (0 when result_err)
//   result_err    out  1      conversion failed; qualified by result_valid
//   result_valid  out  1      result/result_err valid
//   result_ready  in   1      consumer takes the result
// Optional feature macro: ASCII2BIN_BACKSPACE_EN
//   defined   : 8'h08 deletes the most recent digit (count saturates at 0)
//   undefined : 8'h08 is treated as any other invalid character
// -----------------------------------------------------------------------------
module module_ascii2binary
    import ascii2bin_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter int         MAX_DIGITS = 3,
    parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ascii_in,
    input  logic             ascii_valid,
    output logic             ascii_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_err,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int DIG_W = 4 * MAX_DIGITS;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   digits_q, digits_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_pend_q, err_pend_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               result_err_q, result_err_d;
    logic               result_valid_q, result_valid_d;

    logic               accept;
    logic [WIDTH-1:0]   conv_bin;
    logic               conv_ovf;

    module_bcd2binary #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_bcd2binary (
        .bcd_in   (digits_q),
        .bin_out  (conv_bin),
        .overflow (conv_ovf)
    );

    assign ascii_ready  = (state_q == IDLE) || (state_q == COLLECT);
    assign accept       = ascii_valid && ascii_ready;

    assign result       = result_q;
    assign result_err   = result_err_q;
    assign result_valid = result_valid_q;

    always_comb begin
        state_d        = state_q;
        digits_d       = digits_q;
        count_d        = count_q;
        err_pend_d     = err_pend_q;
        result_d       = result_q;
        result_err_d   = result_err_q;
        result_valid_d = result_valid_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (ascii_in == TERM_CHAR) begin
                        state_d = CONVERT;
                    end else if (is_digit(ascii_in)) begin
                        if (count_q < CNT_W'(MAX_DIGITS)) begin
                            // Low nibble of '0'..'9' is the digit value itself.
                            digits_d = DIG_W'({digits_q, ascii_in[3:0]});
                            count_d  = count_q + CNT_W'(1);
                            state_d  = COLLECT;
                        end else begin
                            // Too many digits: keep what we have, flag the line.
                            err_pend_d = 1'b1;
                        end
`ifdef ASCII2BIN_BACKSPACE_EN
                    end else if (ascii_in == ASCII_BS) begin
                        // Drop the newest digit; err_pend is deliberately kept.
                        digits_d = digits_q >> 4;
                        if (count_q != '0) begin
                            count_d = count_q - CNT_W'(1);
                        end
                        state_d = (count_q <= CNT_W'(1)) ? IDLE : COLLECT;
`endif
                    end else begin
                        // Invalid byte: remember it, report once at TERM_CHAR.
                        err_pend_d = 1'b1;
                    end
                end
            end

            CONVERT: begin
                result_err_d   = err_pend_q | (count_q == '0) | conv_ovf;
                result_d       = result_err_d ? '0 : conv_bin;
                result_valid_d = 1'b1;
                state_d        = HOLD;
            end

            HOLD: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    digits_d       = '0;
                    count_d        = '0;
                    err_pend_d     = 1'b0;
                    state_d        = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            digits_q       <= '0;
            count_q        <= '0;
            err_pend_q     <= 1'b0;
            result_q       <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            digits_q       <= digits_d;
            count_q        <= count_d;
            err_pend_q     <= err_pend_d;
            result_q       <= result_d;
            result_err_q   <= result_err_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule : module_ascii2binary

// File: tb/tb_module_ascii2binary.sv
// -----------------------------------------------------------------------------
// tb_module_ascii2binary
// Directed and randomized stimulus for module_ascii2binary with a
// line-level reference model. Honours ASCII2BIN_BACKSPACE_EN when defined.
// -----------------------------------------------------------------------------
module tb_module_ascii2binary;

    localparam int         WIDTH      = 8;
    localparam int         MAX_DIGITS = 3;
    localparam logic [7:0] CR         = 8'h0D;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       ascii_in;
    logic             ascii_valid;
    logic             ascii_ready;
    logic [WIDTH-1:0] result;
    logic             result_err;
    logic             result_valid;
    logic             result_ready;

    int n_cmp = 0;
    int n_err = 0;
    int n_results = 0;

    logic [7:0] line_q[$];

    module_ascii2binary #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .TERM_CHAR  (CR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ascii_in     (ascii_in),
        .ascii_valid  (ascii_valid),
        .ascii_ready  (ascii_ready),
        .result       (result),
        .result_err   (result_err),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Number of results handed over to the consumer.
    always @(posedge clk) begin
        if (rst_n && result_valid && result_ready) n_results <= n_results + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line-level reference: digits kept in a list, decimal value by plain arithmetic.
    function automatic void model(output int val, output logic err);
        int   dq[$];
        logic bad;
        bad = 1'b0;
        val = 0;
        foreach (line_q[i]) begin
            if (line_q[i] == CR) break;
            if (line_q[i] >= 8'h30 && line_q[i] <= 8'h39) begin
                if (dq.size() < MAX_DIGITS) dq.push_back(int'(line_q[i]) - 48);
                else bad = 1'b1;
            end
`ifdef ASCII2BIN_BACKSPACE_EN
            else if (line_q[i] == 8'h08) begin
                if (dq.size() > 0) void'(dq.pop_back());
            end
`endif
            else bad = 1'b1;
        end
        foreach (dq[i]) val = val * 10 + dq[i];
        err = bad || (dq.size() == 0) || (val > (2**WIDTH - 1));
        if (err) val = 0;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_char(input logic [7:0] c);
        int n = 0;
        ascii_in    = c;
        ascii_valid = 1'b1;
        while (!ascii_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1 ascii_valid = 1'b0;
        @(negedge clk);
    endtask

    // Sends line_q (ending in CR) with result_ready high and checks the
    // result pulse two cycles after CR acceptance.
    task automatic run_line(input int exp_val, input logic exp_err, input string tag);
        int base;
        base = n_results;
        foreach (line_q[i]) send_char(line_q[i]);
        check({tag, "_n1_valid"}, 32'(result_valid), 32'(0));
        @(negedge clk);
        check({tag, "_n2_valid"}, 32'(result_valid), 32'(1));
        check({tag, "_result"}, 32'(result), 32'(exp_val));
        check({tag, "_err"}, 32'(result_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_n3_valid"}, 32'(result_valid), 32'(0));
        check({tag, "_n3_ready"}, 32'(ascii_ready), 32'(1));
        check({tag, "_count"}, 32'(n_results), 32'(base + 1));
    endtask

    initial begin
        int         v;
        logic       e;
        int         base;
        int         len;
        int         r;
        logic [7:0] c;

        rst_n        = 1'b0;
        ascii_in     = 8'h00;
        ascii_valid  = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_result", 32'(result), 32'(0));
        check("rst_err", 32'(result_err), 32'(0));
        check("rst_valid", 32'(result_valid), 32'(0));
        check("rst_ready", 32'(ascii_ready), 32'(1));
        rst_n = 1'b1;
        @(negedge clk);

        line_q = '{8'h31, 8'h35, 8'h33, CR};
        run_line(153, 1'b0, "l153");
        line_q = '{8'h32, 8'h35, 8'h35, CR};
        run_line(255, 1'b0, "l255");
        line_q = '{8'h32, 8'h35, 8'h36, CR};
        run_line(0, 1'b1, "l256");
        line_q = '{8'h31, 8'h32, 8'h33, 8'h34, CR};
        run_line(0, 1'b1, "l1234");
        line_q = '{CR};
        run_line(0, 1'b1, "empty");
        line_q = '{8'h34, 8'h41, 8'h32, CR};
        run_line(0, 1'b1, "l4A2");
        line_q = '{8'h30, 8'h30, 8'h37, CR};
        run_line(7, 1'b0, "l007");
        line_q = '{8'h31, 8'h39, 8'h08, 8'h35, CR};
`ifdef ASCII2BIN_BACKSPACE_EN
        run_line(15, 1'b0, "bs");
`else
        run_line(0, 1'b1, "bs");
`endif

        // Back-pressure: result held, pending '7' must wait.
        result_ready = 1'b0;
        base = n_results;
        send_char(8'h39);
        send_char(CR);
        ascii_in    = 8'h37;
        ascii_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 32'(result_valid), 32'(1));
            check("hold_result", 32'(result), 32'(9));
            check("hold_err", 32'(result_err), 32'(0));
            check("hold_ready", 32'(ascii_ready), 32'(0));
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("hold_count", 32'(n_results), 32'(base + 1));
        line_q = '{8'h37, CR};
        run_line(7, 1'b0, "after_hold");

        // Asynchronous reset mid-line.
        send_char(8'h31);
        send_char(8'h32);
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", 32'(result), 32'(0));
        check("arst_err", 32'(result_err), 32'(0));
        check("arst_valid", 32'(result_valid), 32'(0));
        check("arst_ready", 32'(ascii_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        line_q = '{8'h33, CR};
        run_line(3, 1'b0, "after_rst");

        // Asynchronous reset while a result is being held.
        result_ready = 1'b0;
        send_char(8'h39);
        send_char(CR);
        @(negedge clk);
        check("hrst_pre_valid", 32'(result_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("hrst_valid", 32'(result_valid), 32'(0));
        check("hrst_result", 32'(result), 32'(0));
        @(negedge clk);
        rst_n        = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);

        // Randomized lines against the reference model.
        for (int n = 0; n < 40; n++) begin
            line_q.delete();
            len = $urandom_range(0, 4);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 99);
                if (r < 85) c = 8'h30 + 8'($urandom_range(0, 9));
                else if (r < 92) c = 8'h08;
                else begin
                    c = 8'($urandom_range(0, 255));
                    if (c == CR) c = 8'h41;
                end
                line_q.push_back(c);
            end
            line_q.push_back(CR);
            model(v, e);
            run_line(v, e, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_module_ascii2binary
